vga_axil_master_fsm: RTL and testbench

Converts a simple single-outstanding native request/response interface into AXI-Lite master transactions on a `vga_axil_if` interface. It issues one read or write at a time and returns the response with error status. It is the initiator for the VGA AXI-Lite register/slave path, used by on-chip control logic and by verification harnesses that drive the VGA slave.

---
 rtl/vga_axil_pkg.sv | 18 +
 rtl/vga_axil_if.sv | 41 ++++
 rtl/vga_axil_master_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_vga_axil_master_fsm.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_axil_pkg.sv
// Shared widths and response codes for the VGA AXI-Lite register path.
// Native requests carry a word address; the AXI-Lite side is byte addressed.
package vga_axil_pkg;

  localparam int AXIL_ADDR_W   = 32;
  localparam int AXIL_DATA_W   = 32;
  localparam int NATIVE_ADDR_W = 30;

  typedef logic [AXIL_ADDR_W-1:0]   axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0]   axil_data_t;
  typedef logic [AXIL_DATA_W/8-1:0] axil_strb_t;
  typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;
  typedef logic [1:0]               axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/vga_axil_if.sv
// AXI-Lite bundle for the VGA register/slave path.
// Ports: clk (rising-edge clock), arst_n (asynchronous active-low reset).
// Modports: master drives AW/W/AR valids+payload and B/R readies;
//           slave drives the complementary signals.
interface vga_axil_if (
  input logic clk,
  input logic arst_n
);
  import vga_axil_pkg::*;

  logic       awvalid;
  logic       awready;
  axil_addr_t awaddr;
  logic       wvalid;
  logic       wready;
  axil_data_t wdata;
  axil_strb_t wstrb;
  logic       bvalid;
  logic       bready;
  axil_resp_t bresp;
  logic       arvalid;
  logic       arready;
  axil_addr_t araddr;
  logic       rvalid;
  logic       rready;
  axil_data_t rdata;
  axil_resp_t rresp;

  modport master (
    input  clk, arst_n,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  clk, arst_n,
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/vga_axil_master_fsm.sv
// Native request/response to AXI-Lite master bridge, one transaction at a time.
// Ports:
//   axil_if      master side of vga_axil_if (also supplies clk and arst_n)
//   req_valid_i  native request present; req_ready_o high only when idle
//   req_write_i  1 = write, 0 = read
//   req_addr_i   word address (sent as byte address {addr, 2'b00})
//   req_wdata_i  write data
//   rsp_valid_o  response available until rsp_ready_i
//   rsp_write_o  response belongs to a write
//   rsp_rdata_o  read data, 0 for writes
//   rsp_err_o    bresp/rresp was not OKAY
// Every output is a flop (or constant), so AXI readies never reach AXI valids
// combinationally.
module vga_axil_master_fsm
  import vga_axil_pkg::*;
(
  vga_axil_if.master   axil_if,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_write_i,
  input  native_addr_t req_addr_i,
  input  axil_data_t   req_wdata_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_write_o,
  output axil_data_t   rsp_rdata_o,
  output logic         rsp_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrData,
    StWrAddr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       clk;
  logic       arst_n;

  logic       accept;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       ar_hs;
  logic       r_hs;

  logic       req_ready;
  logic       awvalid;
  logic       wvalid;
  logic       bready;
  logic       arvalid;
  logic       rready;
  logic       rsp_valid;
  axil_addr_t awaddr;
  axil_addr_t araddr;
  axil_data_t wdata;
  logic       rsp_write;
  logic       rsp_err;
  axil_data_t rsp_rdata;

  // Word address to byte address, zero-extended to the AXI address width.
  function automatic axil_addr_t word_to_byte(input native_addr_t a);
    axil_addr_t b;
    b = '0;
    b[$bits(native_addr_t)+1:0] = {a, 2'b00};
    return b;
  endfunction

  assign clk    = axil_if.clk;
  assign arst_n = axil_if.arst_n;

  assign accept = req_valid_i && req_ready && (state == StIdle);
  assign aw_hs  = awvalid && axil_if.awready;
  assign w_hs   = wvalid  && axil_if.wready;
  assign b_hs   = bready  && axil_if.bvalid;
  assign ar_hs  = arvalid && axil_if.arready;
  assign r_hs   = rready  && axil_if.rvalid;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      StIdle: begin
        if (accept) begin
          state_next = req_write_i ? StWrAddrData : StRdAddr;
        end
      end
      StWrAddrData: begin
        // AW and W may complete in either order; remember which one is left.
        if (aw_hs && w_hs) begin
          state_next = StWrResp;
        end else if (aw_hs) begin
          state_next = StWrData;
        end else if (w_hs) begin
          state_next = StWrAddr;
        end
      end
      StWrData: begin
        if (w_hs) state_next = StWrResp;
      end
      StWrAddr: begin
        if (aw_hs) state_next = StWrResp;
      end
      StWrResp: begin
        if (b_hs) state_next = StRsp;
      end
      StRdAddr: begin
        if (ar_hs) state_next = StRdData;
      end
      StRdData: begin
        if (r_hs) state_next = StRsp;
      end
      StRsp: begin
        if (rsp_ready_i) state_next = StIdle;
      end
      default: state_next = StIdle;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode, so they
  // line up with the state they belong to while staying pure flops.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      req_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_next == StIdle);
      awvalid   <= (state_next == StWrAddrData) || (state_next == StWrAddr);
      wvalid    <= (state_next == StWrAddrData) || (state_next == StWrData);
      bready    <= (state_next == StWrResp);
      arvalid   <= (state_next == StRdAddr);
      rready    <= (state_next == StRdData);
      rsp_valid <= (state_next == StRsp);
    end
  end

  // Payload registers only load on accept or on the response handshake, which
  // keeps addr/data stable under a pending valid and the response stable in StRsp.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        awaddr <= word_to_byte(req_addr_i);
        araddr <= word_to_byte(req_addr_i);
        if (req_write_i) begin
          wdata <= req_wdata_i;
        end
      end
      if ((state == StWrResp) && b_hs) begin
        rsp_write <= 1'b1;
        rsp_err   <= (axil_if.bresp != RESP_OKAY);
        rsp_rdata <= '0;
      end
      if ((state == StRdData) && r_hs) begin
        rsp_write <= 1'b0;
        rsp_err   <= (axil_if.rresp != RESP_OKAY);
        rsp_rdata <= axil_if.rdata;
      end
    end
  end

  assign axil_if.awvalid = awvalid;
  assign axil_if.awaddr  = awaddr;
  assign axil_if.wvalid  = wvalid;
  assign axil_if.wdata   = wdata;
  assign axil_if.wstrb   = '1;
  assign axil_if.bready  = bready;
  assign axil_if.arvalid = arvalid;
  assign axil_if.araddr  = araddr;
  assign axil_if.rready  = rready;

  assign req_ready_o = req_ready;
  assign rsp_valid_o = rsp_valid;
  assign rsp_write_o = rsp_write;
  assign rsp_rdata_o = rsp_rdata;
  assign rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// Bench for vga_axil_master_fsm: a behavioural AXI-Lite slave with per-channel
// ready/response delays and its own memory, plus a word-addressed reference
// memory updated from the native requests.
`timescale 1ns/1ps
module tb_vga_axil_master_fsm;
  import vga_axil_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  vga_axil_if axil (.clk(clk), .arst_n(arst_n));

  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  native_addr_t req_addr;
  axil_data_t   req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_write;
  axil_data_t   rsp_rdata;
  logic         rsp_err;

  vga_axil_master_fsm dut (
    .axil_if     (axil),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  int total = 0;
  int bad   = 0;

  // Slave configuration, written only by the main sequence.
  int         txn_id = 0;
  int         cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  axil_resp_t cfg_resp = RESP_OKAY;

  // Slave observations, written only by the slave process.
  int         aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, viol = 0;
  axil_addr_t got_awaddr = '0;
  axil_addr_t got_araddr = '0;
  axil_data_t got_wdata  = '0;
  axil_strb_t got_wstrb  = '0;
  axil_data_t slave_mem [native_addr_t];

  // Reference memory, written only by the main sequence.
  axil_data_t ref_mem [native_addr_t];

  // Contents of a word that was never written.
  function automatic axil_data_t dflt(input native_addr_t a);
    return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Slave: decides readies/responses at the falling edge for the next rising edge.
  initial begin : slave
    int   seen_id;
    int   aw_w, w_w, b_w, ar_w, r_w;
    logic aw_seen, w_seen, ar_seen, aw_done, w_done, ar_done, b_sent, r_sent;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    axil_addr_t p_awa, p_ara;
    axil_data_t p_wd;
    seen_id = 0;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; aw_done = 0; w_done = 0; ar_done = 0;
    b_sent = 0; r_sent = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = '0; p_ara = '0; p_wd = '0;
    axil.awready = 0; axil.wready = 0; axil.arready = 0;
    axil.bvalid = 0; axil.bresp = RESP_OKAY;
    axil.rvalid = 0; axil.rresp = RESP_OKAY; axil.rdata = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        axil.awready = 0; axil.wready = 0; axil.arready = 0;
        axil.bvalid = 0; axil.rvalid = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_done = 0; w_done = 0; ar_done = 0;
        b_sent = 0; r_sent = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        continue;
      end
      if (seen_id != txn_id) begin
        seen_id = txn_id;
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_done = 0; w_done = 0; ar_done = 0;
        b_sent = 0; r_sent = 0;
        aw_w = cfg_aw_d; w_w = cfg_w_d; b_w = cfg_b_d; ar_w = cfg_ar_d; r_w = cfg_r_d;
      end
      // A valid left waiting must stay up with the same payload.
      if (p_awv && !p_awr && (!axil.awvalid || axil.awaddr !== p_awa)) viol++;
      if (p_wv && !p_wr && (!axil.wvalid || axil.wdata !== p_wd)) viol++;
      if (p_arv && !p_arr && (!axil.arvalid || axil.araddr !== p_ara)) viol++;
      // A valid must drop once its handshake is done.
      if (aw_done && axil.awvalid) viol++;
      if (w_done && axil.wvalid) viol++;
      if (ar_done && axil.arvalid) viol++;
      if (aw_seen) aw_done = 1;
      if (w_seen) w_done = 1;
      if (ar_seen) ar_done = 1;
      // B only after both AW and W handshakes.
      if (b_sent) axil.bvalid = 0;
      else if (aw_seen && w_seen) begin
        if (b_w == 0) begin axil.bvalid = 1; axil.bresp = cfg_resp; end
        else b_w--;
      end
      if (axil.bvalid && axil.bready && !b_sent) begin
        b_sent = 1;
        b_cnt++;
        if (cfg_resp == RESP_OKAY) slave_mem[got_awaddr[31:2]] = got_wdata;
      end
      // R only after the AR handshake.
      if (r_sent) axil.rvalid = 0;
      else if (ar_seen) begin
        if (r_w == 0) begin
          axil.rvalid = 1;
          axil.rresp  = cfg_resp;
          axil.rdata  = slave_mem.exists(got_araddr[31:2]) ? slave_mem[got_araddr[31:2]]
                                                           : dflt(got_araddr[31:2]);
        end else r_w--;
      end
      if (axil.rvalid && axil.rready && !r_sent) begin
        r_sent = 1;
        r_cnt++;
      end
      if (axil.awvalid && !aw_seen) begin
        if (aw_w == 0) begin
          axil.awready = 1; aw_seen = 1; aw_cnt++; got_awaddr = axil.awaddr;
        end else begin
          axil.awready = 0; aw_w--;
        end
      end else axil.awready = 0;
      if (axil.wvalid && !w_seen) begin
        if (w_w == 0) begin
          axil.wready = 1; w_seen = 1; w_cnt++; got_wdata = axil.wdata; got_wstrb = axil.wstrb;
        end else begin
          axil.wready = 0; w_w--;
        end
      end else axil.wready = 0;
      if (axil.arvalid && !ar_seen) begin
        if (ar_w == 0) begin
          axil.arready = 1; ar_seen = 1; ar_cnt++; got_araddr = axil.araddr;
        end else begin
          axil.arready = 0; ar_w--;
        end
      end else axil.arready = 0;
      p_awv = axil.awvalid; p_awr = axil.awready; p_awa = axil.awaddr;
      p_wv  = axil.wvalid;  p_wr  = axil.wready;  p_wd  = axil.wdata;
      p_arv = axil.arvalid; p_arr = axil.arready; p_ara = axil.araddr;
    end
  end

  task automatic run_txn(input logic wr, input native_addr_t a, input axil_data_t d,
                         input int awd, input int wd, input int bd, input int ard,
                         input int rd, input axil_resp_t resp, input int hold);
    int         n, lat, exp_lat;
    int         aw0, w0, b0, ar0, r0;
    logic       exp_err;
    axil_data_t exp_rdata;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_idle", 64'(req_ready), 64'(1));
    cfg_aw_d = awd; cfg_w_d = wd; cfg_b_d = bd; cfg_ar_d = ard; cfg_r_d = rd;
    cfg_resp = resp;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    txn_id++;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    rsp_ready = (hold == 0);
    tick();
    // The block must have captured the request; scramble the inputs.
    req_valid = 0;
    req_write = 1'($urandom);
    req_addr  = 30'($urandom);
    req_wdata = 32'($urandom);
    check("req_ready_busy", 64'(req_ready), 64'(0));
    if (wr) begin
      check("cyc1_aw_w_valid", 64'({axil.awvalid, axil.wvalid, axil.arvalid}), 64'(3'b110));
      check("cyc1_awaddr", 64'(axil.awaddr), 64'({a, 2'b00}));
      check("cyc1_wdata", 64'(axil.wdata), 64'(d));
      check("cyc1_wstrb", 64'(axil.wstrb), 64'(4'hF));
    end else begin
      check("cyc1_ar_valid", 64'({axil.awvalid, axil.wvalid, axil.arvalid}), 64'(3'b001));
      check("cyc1_araddr", 64'(axil.araddr), 64'({a, 2'b00}));
    end
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    exp_lat = wr ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    exp_err   = (resp != RESP_OKAY);
    exp_rdata = wr ? '0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    check("rsp_write", 64'(rsp_write), 64'(wr));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_payload", 64'({rsp_write, rsp_err, rsp_rdata}), 64'({wr, exp_err, exp_rdata}));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("rsp_done_valid", 64'(rsp_valid), 64'(0));
    check("rsp_done_req_ready", 64'(req_ready), 64'(1));
    if (wr) begin
      check("wr_hs_counts", 64'({8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0)}),
            64'(32'h01010100));
      check("wr_slave_awaddr", 64'(got_awaddr), 64'({a, 2'b00}));
      check("wr_slave_wdata", 64'(got_wdata), 64'(d));
      check("wr_slave_wstrb", 64'(got_wstrb), 64'(4'hF));
      if (resp == RESP_OKAY) ref_mem[a] = d;
    end else begin
      check("rd_hs_counts", 64'({8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)}),
            64'(32'h00000101));
      check("rd_slave_araddr", 64'(got_araddr), 64'({a, 2'b00}));
    end
    check("axi_protocol", 64'(viol), 64'(0));
  endtask

  initial begin : main
    int n, b0;
    logic wr;
    native_addr_t a;
    axil_data_t d;
    axil_resp_t resp;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    arst_n = 1;
    #1 arst_n = 0;
    repeat (3) tick();
    check("rst_valids", 64'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready,
                             axil.rready, rsp_valid, req_ready}), 64'(0));
    check("rst_awaddr", 64'(axil.awaddr), 64'(0));
    check("rst_araddr", 64'(axil.araddr), 64'(0));
    check("rst_wdata", 64'(axil.wdata), 64'(0));
    check("rst_wstrb", 64'(axil.wstrb), 64'(4'hF));
    check("rst_rsp", 64'({rsp_write, rsp_err, rsp_rdata}), 64'(0));
    arst_n = 1;
    check("req_ready_first_cycle", 64'(req_ready), 64'(0));
    tick();
    check("req_ready_after_release", 64'(req_ready), 64'(1));

    // Directed transactions.
    run_txn(1'b1, 30'h5, 32'hDEADBEEF, 0, 0, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b1, 30'h3, 32'h12345678, 0, 0, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b0, 30'h3, 32'h0,        0, 0, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b1, 30'h7, 32'hA5A55A5A, 0, 2, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b1, 30'h8, 32'h0BADF00D, 2, 0, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b0, 30'h9, 32'h0,        0, 0, 0, 0, 0, RESP_SLVERR, 5);

    // Reset while waiting for B: the write to word 3 must be abandoned.
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 8; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_resp = RESP_OKAY;
    b0 = b_cnt;
    txn_id++;
    req_valid = 1; req_write = 1; req_addr = 30'h3; req_wdata = 32'hFFFF0000;
    tick();
    req_valid = 0;
    n = 0;
    while (!axil.bready && n < 20) begin tick(); n++; end
    check("bready_before_reset", 64'(axil.bready), 64'(1));
    #2 arst_n = 0;
    #1;
    check("midrst_outputs", 64'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready,
                                 axil.rready, rsp_valid, req_ready}), 64'(0));
    tick();
    tick();
    arst_n = 1;
    check("midrst_req_ready_first", 64'(req_ready), 64'(0));
    tick();
    check("midrst_req_ready_after", 64'(req_ready), 64'(1));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_no_b", 64'(b_cnt - b0), 64'(0));
    run_txn(1'b0, 30'h3, 32'h0, 0, 0, 0, 0, 0, RESP_OKAY, 0);

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int t = 0; t < 24; t++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 30'($urandom_range(0, 15));
      d    = 32'($urandom);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      run_txn(wr, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), resp, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
